// File: rtl/mem_arbiter_nch_if.sv
// Requester-side and downstream-side signal bundle for the N-channel memory arbiter.
// The arbiter uses the slave view; the requester/memory environment uses the master view.
interface mem_arbiter_nch_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 256
);
  localparam int unsigned IdW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]        req_read;
  logic [NUM_CH-1:0]        req_write;
  logic [NUM_CH*ADDR_W-1:0] req_address;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]        req_rdata;
  logic [NUM_CH-1:0]        req_resp;

  logic                     mem_read;
  logic                     mem_write;
  logic [ADDR_W-1:0]        mem_address;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;
  logic                     mem_resp;

  logic                     busy;
  logic [IdW-1:0]           grant_id;

  modport slave (
    input  req_read, req_write, req_address, req_wdata, mem_rdata, mem_resp,
    output req_rdata, req_resp, mem_read, mem_write, mem_address, mem_wdata, busy, grant_id
  );

  modport master (
    output req_read, req_write, req_address, req_wdata, mem_rdata, mem_resp,
    input  req_rdata, req_resp, mem_read, mem_write, mem_address, mem_wdata, busy, grant_id
  );
endinterface

// File: rtl/mem_arbiter_nch.sv
// N-channel cacheline arbiter: one winner per transaction, fields latched at grant,
// fixed-priority (ch0 highest) or round-robin selection.
module mem_arbiter_nch #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned RR_MODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  mem_arbiter_nch_if.slave bus
);
  localparam int unsigned IdW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [IdW-1:0]    grant_q, grant_d;
  logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
  logic              is_write_q, is_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [NUM_CH-1:0] pending;
  logic [IdW-1:0]    base;
  logic [IdW:0]      cand;
  logic [IdW-1:0]    win_idx;
  logic              win_found;

  assign pending = bus.req_read | bus.req_write;
  assign base    = (RR_MODE != 0) ? rr_ptr_q : '0;

  // Walk channels starting at base, wrapping modulo NUM_CH; first pending one wins.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, base} + (IdW+1)'(i);
      if (cand >= (IdW+1)'(NUM_CH)) begin
        cand = cand - (IdW+1)'(NUM_CH);
      end
      if (!win_found && pending[cand[IdW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IdW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d    = StBusy;
          grant_d    = win_idx;
          // Read and write together on one channel resolves to a write.
          is_write_d = bus.req_write[win_idx];
          addr_d     = bus.req_address[32'(win_idx) * ADDR_W +: ADDR_W];
          wdata_d    = bus.req_wdata[32'(win_idx) * DATA_W +: DATA_W];
        end
      end
      StBusy: begin
        if (bus.mem_resp) begin
          state_d = StIdle;
          if (RR_MODE != 0) begin
            rr_ptr_d = (grant_q == IdW'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.busy        = 1'b0;
    bus.req_resp    = '0;
    bus.req_rdata   = bus.mem_rdata;
    bus.mem_address = addr_q;
    bus.mem_wdata   = wdata_q;
    bus.grant_id    = grant_q;
    if (state_q == StBusy) begin
      bus.busy      = 1'b1;
      bus.mem_read  = !is_write_q;
      bus.mem_write = is_write_q;
      // A completion coinciding with reset is abandoned, not reported.
      if (bus.mem_resp && !reset) begin
        bus.req_resp[grant_q] = 1'b1;
      end
    end
  end
endmodule
